// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock through a BITS+1-wide prefix adder.
// Optional MUL_OVF_FLAG_EN adds a registered ovf output (product does not fit in BITS signed bits).
module booth_multiplier #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [BITS-1:0] multiplicand,
    input  logic [BITS-1:0] multiplier,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] product_hi,
`ifdef MUL_OVF_FLAG_EN
    output logic [BITS-1:0] product_lo,
    output logic            ovf
`else
    output logic [BITS-1:0] product_lo
`endif
);

    localparam int AW = BITS + 1;
    localparam int LV = $clog2(AW);
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic [BITS-1:0] r_m;
    logic [AW-1:0]   r_a;
    logic [BITS-1:0] r_q;
    logic            r_qm1;
    logic [CW-1:0]   r_count;
    logic [BITS-1:0] r_hi;
    logic [BITS-1:0] r_lo;

    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [AW-1:0]   w_sext_m;
    logic [AW-1:0]   w_addend;
    logic            w_cin;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_a_sh;
    logic [BITS-1:0] w_q_sh;

    // Kogge-Stone carry-lookahead add; carry-in folded into the bit-0 generate, carry-out dropped.
    function automatic logic [AW-1:0] cla_add(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                              input logic cin);
        logic [AW-1:0] g [0:LV];
        logic [AW-1:0] p [0:LV];
        logic [AW-1:0] c;
        g[0]    = x & y;
        p[0]    = x ^ y;
        g[0][0] = g[0][0] | (p[0][0] & cin);
        for (int lv = 1; lv <= LV; lv++) begin
            for (int i = 0; i < AW; i++) begin
                if (i >= (1 << (lv - 1))) begin
                    g[lv][i] = g[lv-1][i] | (p[lv-1][i] & g[lv-1][i-(1<<(lv-1))]);
                    p[lv][i] = p[lv-1][i] & p[lv-1][i-(1<<(lv-1))];
                end else begin
                    g[lv][i] = g[lv-1][i];
                    p[lv][i] = p[lv-1][i];
                end
            end
        end
        c = {g[LV][AW-2:0], cin};
        return p[0] ^ c;
    endfunction

    assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_step = (r_state == RUN);
    assign w_last = w_step && (r_count == CW'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_sext_m = {r_m[BITS-1], r_m};
        w_addend = '0;
        w_cin    = 1'b0;
        unique case ({r_q[0], r_qm1})
            2'b01:   w_addend = w_sext_m;
            2'b10: begin
                w_addend = ~w_sext_m;
                w_cin    = 1'b1;
            end
            default: w_addend = '0;
        endcase
        w_sum  = cla_add(r_a, w_addend, w_cin);
        w_a_sh = {w_sum[BITS], w_sum[BITS:1]};
        w_q_sh = {w_sum[0], r_q[BITS-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // NOTE: clr clears operand and iteration registers too, so an aborted run leaves nothing behind.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_load) begin
            r_m     <= multiplicand;
            r_a     <= '0;
            r_q     <= multiplier;
            r_qm1   <= 1'b0;
            r_count <= CW'(BITS);
        end else if (w_step) begin
            r_a     <= w_a_sh;
            r_q     <= w_q_sh;
            r_qm1   <= r_q[0];
            r_count <= r_count - CW'(1);
            if (w_last) begin
                r_hi <= w_a_sh[BITS-1:0];
                r_lo <= w_q_sh;
            end
        end
    end

`ifdef MUL_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (w_a_sh[BITS-1:0] != {BITS{w_q_sh[BITS-1]}});
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign product_hi = r_hi;
    assign product_lo = r_lo;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (BITS=32): latency, signed products,
// ignored mid-run start, asynchronous clr abort and back-to-back operation.
module tb_booth_multiplier;

    localparam int BITS    = 32;
    localparam int LATENCY = 33;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
`ifdef MUL_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    booth_multiplier #(.BITS(BITS)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
`ifdef MUL_OVF_FLAG_EN
        .product_lo   (product_lo),
        .ovf          (ovf)
`else
        .product_lo   (product_lo)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Counts rising edges (starting with the next one) until done is seen, bounded by TIMEOUT.
    task automatic wait_done(output int n);
        n = 0;
        while (n < TIMEOUT) begin
            @(posedge clk);
            n++;
            #1;
            if (done === 1'b1) return;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_hi"}, 64'(product_hi), 64'(v.hi));
        check({tag, "_lo"}, 64'(product_lo), 64'(v.lo));
`ifdef MUL_OVF_FLAG_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(v.ovf));
`endif
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n;
        @(negedge clk);
        multiplicand = v.m;
        multiplier   = v.q;
        start        = 1'b1;
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'(LATENCY));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check_result(tag, v);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'(0));
    endtask

    vec_t vecs [9];

    initial begin
        int  n;
        int  n2;
        bit  seen;
        vec_t v;

        vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F, 1'b0};
        vecs[1] = '{32'hFFFF_FFF9, 32'd6,       32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'd9,        32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFDC, 1'b0};

        clr          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1 clr = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(product_hi), 64'(0));
        check("rst_lo", 64'(product_lo), 64'(0));
`ifdef MUL_OVF_FLAG_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Mid-run start with other operands must be ignored.
        @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'hFFFF_FFFC;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_busy", 64'(busy), 64'(1));
        n = 1;
        while (n < TIMEOUT) begin
            if (n == 10) begin
                @(negedge clk);
                multiplicand = 32'd100;
                multiplier   = 32'd100;
                start        = 1'b1;
            end
            @(posedge clk);
            n++;
            #1 start = 1'b0;
            if (done === 1'b1) break;
        end
        check("ign_lat", 64'(n), 64'(LATENCY));
        check_result("ign", vecs[8]);

        // Asynchronous clr in the middle of a run.
        @(negedge clk);
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_done", 64'(done), 64'(0));
        check("clr_hi", 64'(product_hi), 64'(0));
        check("clr_lo", 64'(product_lo), 64'(0));
        @(negedge clk);
        clr  = 1'b0;
        seen = 1'b0;
        repeat (TIMEOUT) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("clr_no_done", 64'(seen), 64'(0));
        check("clr_idle_busy", 64'(busy), 64'(0));
        run_vec("after_clr", vecs[0]);

        // start held high: 2x3 then 4x5, one result per LATENCY cycles.
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 32'd4;
        multiplier   = 32'd5;
        wait_done(n);
        check("b2b_lat1", 64'(n + 1), 64'(LATENCY));
        v = '{32'd2, 32'd3, 32'd0, 32'd6, 1'b0};
        check_result("b2b1", v);
        wait_done(n2);
        check("b2b_lat2", 64'(n2), 64'(LATENCY));
        v = '{32'd4, 32'd5, 32'd0, 32'd20, 1'b0};
        check_result("b2b2", v);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_end_done", 64'(done), 64'(0));
        check("b2b_end_busy", 64'(busy), 64'(0));
        check("b2b_hold_lo", 64'(product_lo), 64'(20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential signed radix-2 Booth multiplier for the datapath ALU. It latches two BITS-wide two's-complement operands on a start strobe and iterates one Booth step per clock. Each step drives a BITS+1-wide carry-lookahead adder stage and consumes its sum as the new partial product. After BITS steps it presents a 2·BITS-bit product split into HI/LO halves, ready for the HI and LO registers.

## Interface
- BITS, 32, operand width; product is 2·BITS bits
- clk  in  1  rising-edge clock
- clr  in  1  reset; asynchronous, active-high, clears all state
- start  in  1  begin multiply; sampled only in IDLE or DONE
- multiplicand  in  BITS  signed operand M, sampled on accepted start
- multiplier  in  BITS  signed operand Q, sampled on accepted start
- busy  out  1  high while iterating (RUN)
- done  out  1  one-cycle pulse, product valid
- product_hi  out  BITS  upper half of signed product
- product_lo  out  BITS  lower half of signed product
- ovf  out  1  present only with MUL_OVF_FLAG_EN (see Configuration)

## Operation
- States: IDLE, RUN, DONE. After clr: IDLE, busy=0, done=0, product_hi=0, product_lo=0, ovf=0, count=0.
- IDLE/DONE + start=1:
  - latch M=multiplicand
  - set A=0 (BITS+1 bits), Q=multiplier, q_m1=0, count=BITS
  - go to RUN
- IDLE + start=0: stay. DONE + start=0: go to IDLE.
- RUN, each cycle, by {Q[0], q_m1}:
  - 01: A = A + sext(M)
  - 10: A = A + ~sext(M) + 1
  - 00/11: A unchanged
  - then arithmetic shift right of {A, Q, q_m1} by one, replicating A[BITS]
  - count decrements
- RUN, on the step where count==1: go to DONE and register product_hi/product_lo.
- Arithmetic:
  - A is BITS+1 bits so the subtraction with M = −2^(BITS−1) cannot overflow.
  - The adder runs at BITS+1 width; only the low BITS+1 sum bits are used, and the carry-out is discarded.
- Product is {A[BITS−1:0], Q} after the final shift.
- product_hi/product_lo hold their value from DONE until the next completion or clr.
- start while in RUN is ignored. Operands are not re-sampled during RUN.
- DONE + start=1 is accepted, giving back-to-back operations with no IDLE gap.
- clr mid-RUN aborts immediately to IDLE with every output reset to 0. No done is produced.

## Timing
- start sampled at edge E0 → busy=1 from E0 through E(BITS).
- Edges E1..E(BITS) each perform one step.
- At E(BITS): state becomes DONE, busy=0, done=1 for exactly one cycle, product valid.
- Latency: BITS+1 cycles from the start edge to the first cycle with done=1. BITS=32 gives 33.
- Back-to-back: start held high during DONE restarts at that edge, so throughput is one result per BITS+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- MUL_OVF_FLAG_EN defined:
  - adds port ovf (out, 1)
  - ovf is registered together with the product
  - ovf = 1 when product_hi ≠ {BITS{product_lo[BITS−1]}}, i.e. the product does not fit in BITS signed bits
  - ovf resets to 0 and is held with the product
- MUL_OVF_FLAG_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- 3 × 5 → at start+33 cycles: done=1, product_hi=0x00000000, product_lo=0x0000000F, ovf=0.
- −7 (0xFFFFFFF9) × 6 → product_hi=0xFFFFFFFF, product_lo=0xFFFFFFD6, ovf=0.
- 0x80000000 × 0x80000000 → product_hi=0x40000000, product_lo=0x00000000, ovf=1. Also 0x80000000 × 0x00000001 → hi=0xFFFFFFFF, lo=0x80000000, ovf=0.
- start pulsed again at cycle 10 of RUN with different operands → ignored. Result is for the original operands, and done is at cycle 33 only.
- clr asserted asynchronously at cycle 15 of RUN → busy, done and products go to 0 immediately. No done follows, and the next start yields a correct result.
- start held high continuously with 2×3 then 4×5 → done pulses 33 cycles apart, products 6 then 20.
